// File: rtl/cpu_if_pkg.sv
// Shared definitions for the APB register-bank front-end.
//   state_t    : transfer sequencer states
//   APB_OKAY/ERR : pslverr encodings
//   reg_idx()  : word index of a byte address (address zero-extended to MAX_AW)
package cpu_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  // Widest paddr supported by reg_idx(); narrower buses are zero-extended.
  localparam int unsigned MAX_AW = 32;

  function automatic logic [MAX_AW-3:0] reg_idx(input logic [MAX_AW-1:0] paddr);
    return paddr[MAX_AW-1:2];
  endfunction

endpackage

// File: rtl/cpu_if_reg_ctrl_if.sv
// APB3 bus bundle between the interconnect (master) and cpu_if_reg_ctrl (slave).
//   psel/penable/pwrite/paddr/pwdata : master -> slave request
//   pready/prdata/pslverr            : slave -> master response
interface cpu_if_reg_ctrl_if #(
  parameter int unsigned WD = 32,
  parameter int unsigned AW = 12
);

  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [WD-1:0] pwdata;
  logic          pready;
  logic [WD-1:0] prdata;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/cpu_if_addr_dec.sv
// Combinational address decoder for the register bank.
//   paddr  in  AW    byte address
//   pwrite in  1     access direction (write-to-RO check)
//   sel    out NREG  one-hot register select, all-zero when err
//   err    out 1     misaligned, unmapped or write to a read-only register
module cpu_if_addr_dec
  import cpu_if_pkg::*;
#(
  parameter int unsigned    AW      = 12,
  parameter int unsigned    NREG    = 8,
  parameter logic [NREG-1:0] RO_MASK = '0
) (
  input  logic [AW-1:0]   paddr,
  input  logic            pwrite,
  output logic [NREG-1:0] sel,
  output logic            err
);

  logic [MAX_AW-1:0] paddr_ext;
  logic [MAX_AW-1:0] idx;
  logic [NREG-1:0]   sel_raw;
  logic              misaligned;
  logic              out_of_range;
  logic              ro_hit;

  always_comb begin
    paddr_ext           = '0;
    paddr_ext[AW-1:0]   = paddr;
    // Range check uses the whole word index so high addresses never alias low registers.
    idx                 = {2'b00, reg_idx(paddr_ext)};
    misaligned          = |paddr[1:0];
    out_of_range        = (idx >= MAX_AW'(NREG));
    sel_raw             = '0;
    ro_hit              = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (idx == i) begin
        sel_raw[i] = 1'b1;
        ro_hit     = RO_MASK[i];
      end
    end
    err = misaligned | out_of_range | (pwrite & ro_hit);
    sel = err ? '0 : sel_raw;
  end

endmodule

// File: rtl/cpu_if_reg_ctrl.sv
// APB3 slave front-end for the register-field bank.
// Each accepted transfer produces exactly one single-cycle cpu_en strobe, and read
// data is captured in that strobe cycle so clear-on-read fields return the old value.
//   clk, rst_n  clock, asynchronous active-low reset
//   apb         APB3 slave port (psel/penable/pwrite/paddr/pwdata/pready/prdata/pslverr)
//   cpu_en      one-hot register strobe, one cycle per good transfer
//   cpu_w_en    write qualifier alongside cpu_en
//   cpu_r_en    read qualifier alongside cpu_en
//   cpu_wdata   write data latched at the setup phase
//   reg_rdata   flattened field read data, register i at [i*WD +: WD]
module cpu_if_reg_ctrl
  import cpu_if_pkg::*;
#(
  parameter int unsigned     WD      = 32,
  parameter int unsigned     AW      = 12,
  parameter int unsigned     NREG    = 8,
  parameter logic [NREG-1:0] RO_MASK = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_if_reg_ctrl_if.slave    apb,
  output logic [NREG-1:0]     cpu_en,
  output logic                cpu_w_en,
  output logic                cpu_r_en,
  output logic [WD-1:0]       cpu_wdata,
  input  logic [NREG*WD-1:0]  reg_rdata
);

  state_t          state;
  state_t          state_nxt;
  logic [NREG-1:0] sel_d;
  logic [NREG-1:0] sel_q;
  logic            err_d;
  logic            err_q;
  logic            pwrite_q;
  logic [WD-1:0]   prdata_q;
  logic [WD-1:0]   rd_mux;
  logic            take_setup;

  cpu_if_addr_dec #(
    .AW      (AW),
    .NREG    (NREG),
    .RO_MASK (RO_MASK)
  ) u_addr_dec (
    .paddr  (apb.paddr),
    .pwrite (apb.pwrite),
    .sel    (sel_d),
    .err    (err_d)
  );

  assign take_setup = (state == IDLE) & apb.psel & ~apb.penable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (take_setup) state_nxt = SETUP;
      SETUP: begin
        if (!apb.psel)        state_nxt = IDLE;
        else if (apb.penable) state_nxt = STROBE;
      end
      STROBE: state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is frozen at the setup phase; later bus changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      err_q     <= 1'b0;
      pwrite_q  <= 1'b0;
      cpu_wdata <= '0;
      prdata_q  <= '0;
    end else begin
      if (take_setup) begin
        sel_q     <= sel_d;
        err_q     <= err_d;
        pwrite_q  <= apb.pwrite;
        cpu_wdata <= apb.pwdata;
      end
      if (state == STROBE) begin
        prdata_q <= (!err_q && !pwrite_q) ? rd_mux : '0;
      end
    end
  end

  // sel_q is all-zero on errored transfers, so the mux yields 0 there.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (sel_q[i]) rd_mux = rd_mux | reg_rdata[i*WD +: WD];
    end
  end

  // Outputs decode straight from the state register so reset removes them at once.
  always_comb begin
    cpu_en      = '0;
    cpu_w_en    = 1'b0;
    cpu_r_en    = 1'b0;
    apb.pready  = 1'b0;
    apb.pslverr = APB_OKAY;
    apb.prdata  = '0;
    if (state == STROBE) begin
      cpu_en   = sel_q;
      cpu_w_en = (|sel_q) & pwrite_q;
      cpu_r_en = (|sel_q) & ~pwrite_q;
    end
    if (state == DONE) begin
      apb.pready  = 1'b1;
      apb.pslverr = err_q ? APB_ERR : APB_OKAY;
      apb.prdata  = prdata_q;
    end
  end

endmodule
